// File: rtl/graphite_cmd_tx.sv
// Command-word transmit queue: CPU strobes words in, they leave in order on an
// AXI-stream master port through a registered output stage.
module graphite_cmd_tx #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n_i,
    input  logic                       cpu_wr_i,
    input  logic [31:0]                cpu_data_i,
    input  logic                       cpu_flush_i,
    input  logic                       cpu_clr_ovf_i,
    output logic                       cmd_axis_tvalid_o,
    input  logic                       cmd_axis_tready_i,
    output logic [31:0]                cmd_axis_tdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // The buffer never holds more than DEPTH-1 words (the output register holds
    // the rest), so equal pointers always mean the buffer is empty.
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          xfer;
    logic          buf_empty;
    logic          wr_ok;
    logic          load_out;
    logic          pop;
    logic          bypass;
    logic          push;
    logic          ovf_set;
    logic          ovf_nxt;
    logic [LW-1:0] level_nxt;

    always_comb begin
        xfer      = cmd_axis_tvalid_o && cmd_axis_tready_i;
        buf_empty = (rd_ptr == wr_ptr);
        wr_ok     = cpu_wr_i && !cpu_flush_i && (!full_o || xfer);
        load_out  = !cmd_axis_tvalid_o || xfer;
        pop       = load_out && !buf_empty && !cpu_flush_i;
        bypass    = load_out && buf_empty && wr_ok;
        push      = wr_ok && !bypass;
        ovf_set   = cpu_wr_i && !cpu_flush_i && full_o && !xfer;
        ovf_nxt   = overflow_o;
        if (ovf_set) begin
            ovf_nxt = 1'b1;
        end else if (cpu_clr_ovf_i) begin
            ovf_nxt = 1'b0;
        end
        level_nxt = level_o;
        if (cpu_flush_i) begin
            level_nxt = (cmd_axis_tvalid_o && !xfer) ? LW'(1) : '0;
        end else if (wr_ok && !xfer) begin
            level_nxt = level_o + LW'(1);
        end else if (!wr_ok && xfer) begin
            level_nxt = level_o - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cpu_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            cmd_axis_tvalid_o <= 1'b0;
            cmd_axis_tdata_o  <= '0;
            level_o           <= '0;
            full_o            <= 1'b0;
            empty_o           <= 1'b1;
            overflow_o        <= 1'b0;
        end else begin
            level_o    <= level_nxt;
            full_o     <= (level_nxt == LW'(DEPTH));
            empty_o    <= (level_nxt == '0);
            overflow_o <= ovf_nxt;
            if (cpu_flush_i) begin
                // Presented word survives a flush; only the queued words behind it go.
                rd_ptr <= wr_ptr;
                if (xfer) begin
                    cmd_axis_tvalid_o <= 1'b0;
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    cmd_axis_tdata_o  <= mem[rd_ptr];
                    cmd_axis_tvalid_o <= 1'b1;
                    rd_ptr            <= rd_ptr + AW'(1);
                end else if (bypass) begin
                    cmd_axis_tdata_o  <= cpu_data_i;
                    cmd_axis_tvalid_o <= 1'b1;
                end else if (load_out) begin
                    cmd_axis_tvalid_o <= 1'b0;
                end
            end
        end
    end

endmodule
